// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: owns the PC and steps each instruction through
// FETCH/EXEC/MEM/WB. Define SEQ_JAL_EN to decode 7'h6F as JAL; otherwise it is illegal.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h28,
    parameter int unsigned MAX_INSNS = 43
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ins,
    input  logic [31:0] PCp4,
    input  logic [31:0] imm,
    input  logic [31:0] jTarget,
    input  logic        zero,
    output logic [31:0] PC,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        Mem2Reg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [15:0] insn_count
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_DONE} state_t;
    typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL} cls_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_INSNS);
    localparam bit          LIMITED = (MAX_INSNS != 0);

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] count_q, count_d;
    logic        illegal_q, illegal_d;

    cls_t        dec_cls;
    logic        dec_legal;
    logic        retire;
    logic [15:0] count_inc;
    logic [31:0] pc_retire;
    logic        unused_in;

`ifdef SEQ_JAL_EN
    assign unused_in = ^{ins[31:7], imm[31], jTarget[31:30]};
`else
    assign unused_in = ^{ins[31:7], imm[31], jTarget};
`endif

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = C_R;
        case (ins[6:0])
            7'h33:   dec_cls = C_R;
            7'h13:   dec_cls = C_I;
            7'h03:   dec_cls = C_LOAD;
            7'h23:   dec_cls = C_STORE;
            7'h63:   dec_cls = C_BRANCH;
`ifdef SEQ_JAL_EN
            7'h6F:   dec_cls = C_JAL;
`endif
            default: dec_legal = 1'b0;
        endcase
    end

    // Branch/jump offsets arrive already sign-extended; shifting drops the top bits.
    always_comb begin
        pc_retire = PCp4;
        if (cls_q == C_BRANCH && zero) begin
            pc_retire = pc_q + {imm[30:0], 1'b0};
        end
`ifdef SEQ_JAL_EN
        if (cls_q == C_JAL) begin
            pc_retire = pc_q + {jTarget[29:0], 2'b00};
        end
`endif
    end

    assign count_inc = count_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        pc_d      = pc_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    count_d   = 16'd0;
                    illegal_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BRANCH:       retire  = 1'b1;
                    C_LOAD,
                    C_STORE:        state_d = S_MEM;
                    default:        state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (cls_q == C_LOAD) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_WB:    retire  = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // The last phase of every path funnels through here.
        if (retire) begin
            pc_d    = pc_retire;
            count_d = count_inc;
            if (LIMITED && count_inc == MAX_CNT) begin
                state_d = S_DONE;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            pc_q      <= RESET_PC;
            count_q   <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Controls decode only from state and the latched class, never from ins.
    always_comb begin
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        Mem2Reg  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        op       = 3'b010;
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ALUSrc   = (cls_q != C_R) && (cls_q != C_BRANCH);
            op       = (cls_q == C_BRANCH) ? 3'b110 : 3'b010;
            Mem2Reg  = (cls_q == C_LOAD);
            RegWrite = (state_q == S_WB);
            MemRead  = (state_q == S_MEM) && (cls_q == C_LOAD);
            MemWrite = (state_q == S_MEM) && (cls_q == C_STORE);
        end
    end

    assign PC         = pc_q;
    assign insn_count = count_q;
    assign illegal    = illegal_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                        (state_q == S_MEM)   || (state_q == S_WB);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer: a cycle-per-phase reference
// model derived from opcode classes predicts controls, PC and retire count.
module tb_instr_sequencer;

    localparam logic [31:0] TB_RESET_PC = 32'h28;
    localparam int          TB_MAX      = 43;

    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LD  = 7'h03;
    localparam logic [6:0] OPC_ST  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ins;
    logic [31:0] PCp4;
    logic [31:0] imm;
    logic [31:0] jTarget;
    logic        zero;

    logic [31:0] PC, PC_u;
    logic        RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite;
    logic        RegWrite_u, ALUSrc_u, Mem2Reg_u, MemRead_u, MemWrite_u;
    logic [2:0]  op, op_u;
    logic        busy, done, illegal;
    logic        busy_u, done_u, illegal_u;
    logic [15:0] insn_count, insn_count_u;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [15:0] exp_count;

    instr_sequencer #(.RESET_PC(TB_RESET_PC), .MAX_INSNS(TB_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .PCp4(PCp4),
        .imm(imm), .jTarget(jTarget), .zero(zero), .PC(PC),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
        .MemRead(MemRead), .MemWrite(MemWrite), .op(op), .busy(busy),
        .done(done), .illegal(illegal), .insn_count(insn_count)
    );

    // Unlimited-run twin fed the same inputs; it must keep going where u_dut stops.
    instr_sequencer #(.RESET_PC(TB_RESET_PC), .MAX_INSNS(0)) u_unl (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .PCp4(PCp4),
        .imm(imm), .jTarget(jTarget), .zero(zero), .PC(PC_u),
        .RegWrite(RegWrite_u), .ALUSrc(ALUSrc_u), .Mem2Reg(Mem2Reg_u),
        .MemRead(MemRead_u), .MemWrite(MemWrite_u), .op(op_u), .busy(busy_u),
        .done(done_u), .illegal(illegal_u), .insn_count(insn_count_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Cycles from FETCH through retire; 0 marks an opcode that must be rejected.
    function automatic int insnCycles(input logic [6:0] opc);
        case (opc)
            OPC_R, OPC_I: return 3;
            OPC_LD:       return 4;
            OPC_ST:       return 3;
            OPC_BR:       return 2;
`ifdef SEQ_JAL_EN
            OPC_JAL:      return 3;
`endif
            default:      return 0;
        endcase
    endfunction

    function automatic logic [6:0] randomLegalOpc();
`ifdef SEQ_JAL_EN
        case ($urandom_range(0, 5))
`else
        case ($urandom_range(0, 4))
`endif
            0:       return OPC_R;
            1:       return OPC_I;
            2:       return OPC_LD;
            3:       return OPC_ST;
            4:       return OPC_BR;
            default: return OPC_JAL;
        endcase
    endfunction

    function automatic logic [31:0] makeInsn(input logic [6:0] opc);
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], opc};
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_pc", PC, TB_RESET_PC);
        checkOutput("rst_ctrl", 32'({RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite}), 32'd0);
        checkOutput("rst_op", 32'(op), 32'd2);
        checkOutput("rst_flags", 32'({busy, done, illegal}), 32'd0);
        checkOutput("rst_count", 32'(insn_count), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = TB_RESET_PC;
        exp_count = 16'd0;
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        exp_pc    = TB_RESET_PC;
        exp_count = 16'd0;
        checkOutput("start_pc", PC, TB_RESET_PC);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_done_illegal", 32'({done, illegal}), 32'd0);
        checkOutput("start_count", 32'(insn_count), 32'd0);
    endtask

    // Called at a negedge while the sequencer sits in FETCH.
    task automatic applyInsn(input string tag, input logic [31:0] insn, input logic [31:0] imm_v,
                             input logic [31:0] jt_v, input logic zero_v);
        logic [6:0] opc;
        int         n;
        logic       has_wb, is_mem, exp_alu, exp_done;
        logic [2:0] exp_op;
        logic [4:0] exp_ctrl;
        opc     = insn[6:0];
        n       = insnCycles(opc);
        ins     = insn;
        imm     = imm_v;
        jTarget = jt_v;
        zero    = zero_v;
        PCp4    = exp_pc + 32'd4;
        #1;
        checkOutput({tag, "_fetch_pc"}, PC, exp_pc);
        checkOutput({tag, "_fetch_ctrl"}, 32'({RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite}), 32'd0);
        checkOutput({tag, "_fetch_op"}, 32'(op), 32'd2);
        checkOutput({tag, "_fetch_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ins = $urandom;
        if (n == 0) begin
            checkOutput({tag, "_ill_flags"}, 32'({busy, done, illegal}), 32'b011);
            checkOutput({tag, "_ill_pc"}, PC, exp_pc);
            checkOutput({tag, "_ill_count"}, 32'(insn_count), 32'(exp_count));
            return;
        end
        exp_alu = (opc != OPC_R) && (opc != OPC_BR);
        exp_op  = (opc == OPC_BR) ? 3'b110 : 3'b010;
        has_wb  = (opc != OPC_ST) && (opc != OPC_BR);
        for (int k = 1; k < n; k++) begin
            is_mem   = ((opc == OPC_LD) || (opc == OPC_ST)) && (k == 2);
            exp_ctrl = {has_wb && (k == n - 1), exp_alu, opc == OPC_LD,
                        is_mem && (opc == OPC_LD), is_mem && (opc == OPC_ST)};
            checkOutput($sformatf("%s_ctrl_k%0d", tag, k),
                        32'({RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite}), 32'(exp_ctrl));
            checkOutput($sformatf("%s_op_k%0d", tag, k), 32'(op), 32'(exp_op));
            checkOutput($sformatf("%s_hold_k%0d", tag, k), PC, exp_pc);
            @(posedge clk);
            @(negedge clk);
        end
        if (opc == OPC_BR && zero_v)
            exp_pc = exp_pc + imm_v * 32'd2;
        else if (opc == OPC_JAL)
            exp_pc = exp_pc + jt_v * 32'd4;
        else
            exp_pc = exp_pc + 32'd4;
        exp_count = exp_count + 16'd1;
        exp_done  = (TB_MAX != 0) && (exp_count == 16'(TB_MAX));
        checkOutput({tag, "_ret_pc"}, PC, exp_pc);
        checkOutput({tag, "_ret_count"}, 32'(insn_count), 32'(exp_count));
        checkOutput({tag, "_ret_busy_done"}, 32'({busy, done}), exp_done ? 32'b01 : 32'b10);
    endtask

    initial begin
        logic [31:0] r_imm, r_jt;
        logic [6:0]  opc;
        rst_n   = 1'b0;
        start   = 1'b0;
        ins     = 32'd0;
        PCp4    = 32'd0;
        imm     = 32'd0;
        jTarget = 32'd0;
        zero    = 1'b0;
        exp_pc  = TB_RESET_PC;
        exp_count = 16'd0;
        #12;
        $display("[TB] reset and directed sequence");
        applyReset();
        applyStimulus();
        applyInsn("add", 32'h002081B3, 32'd0, 32'd0, 1'b0);
        checkOutput("add_pc_const", PC, 32'h2C);
        applyInsn("load", 32'h0000A183, 32'd0, 32'd0, 1'b0);
        checkOutput("load_pc_const", PC, 32'h30);
        applyInsn("addi", makeInsn(OPC_I), 32'd0, 32'd0, 1'b0);
        applyInsn("store", makeInsn(OPC_ST), 32'd0, 32'd0, 1'b1);
        applyInsn("addi2", makeInsn(OPC_I), 32'd0, 32'd0, 1'b0);
        applyInsn("add2", makeInsn(OPC_R), 32'd0, 32'd0, 1'b1);
        checkOutput("pre_branch_pc", PC, 32'h40);
        applyInsn("br_taken", makeInsn(OPC_BR), 32'd8, 32'd0, 1'b1);
        checkOutput("br_taken_pc", PC, 32'h50);
        applyInsn("br_back", makeInsn(OPC_BR), 32'hFFFFFFF8, 32'd0, 1'b1);
        checkOutput("br_back_pc", PC, 32'h40);
        applyInsn("br_not", makeInsn(OPC_BR), 32'd8, 32'd0, 1'b0);
        checkOutput("br_not_pc", PC, 32'h44);

        $display("[TB] randomized run to the retire limit");
        while (exp_count < 16'(TB_MAX)) begin
            opc   = randomLegalOpc();
            r_imm = 32'($urandom_range(0, 63)) - 32'd32;
            r_jt  = 32'($urandom_range(0, 63)) - 32'd32;
            applyInsn("rnd", makeInsn(opc), r_imm, r_jt, 1'($urandom_range(0, 1)));
        end
        checkOutput("limit_done", 32'(done), 32'd1);
        checkOutput("unl_busy", 32'({busy_u, done_u}), 32'b10);
        checkOutput("unl_count", 32'(insn_count_u), 32'(TB_MAX));
        ins = makeInsn(OPC_R);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("done_held", 32'({busy, done}), 32'b01);
        checkOutput("done_pc_held", PC, exp_pc);

        $display("[TB] reset during store MEM phase");
        applyStimulus();
        ins = makeInsn(OPC_ST);
        PCp4 = exp_pc + 32'd4;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("st_mem_write", 32'(MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_memwrite", 32'(MemWrite), 32'd0);
        checkOutput("abort_pc", PC, TB_RESET_PC);
        checkOutput("abort_flags", 32'({busy, done}), 32'd0);
        checkOutput("abort_count", 32'(insn_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        applyInsn("post_abort", makeInsn(OPC_R), 32'd0, 32'd0, 1'b0);
        checkOutput("post_abort_count", 32'(insn_count), 32'd1);

        $display("[TB] illegal opcode");
        applyInsn("illegal", {25'h1ABCDE, 7'h7F}, 32'd0, 32'd0, 1'b0);
        checkOutput("illegal_count_const", 32'(insn_count), 32'd1);
        applyStimulus();

        $display("[TB] jump");
        applyInsn("jal", makeInsn(OPC_JAL), 32'd0, 32'd3, 1'b0);
`ifdef SEQ_JAL_EN
        checkOutput("jal_pc_const", PC, 32'h34);
        checkOutput("jal_count_const", 32'(insn_count), 32'd1);
`else
        checkOutput("jal_pc_const", PC, 32'h28);
        checkOutput("jal_illegal_const", 32'(illegal), 32'd1);
        checkOutput("jal_count_const", 32'(insn_count), 32'd0);
`endif

        $display("[TB] PC wrap-around");
        applyReset();
        applyStimulus();
        applyInsn("br_far", makeInsn(OPC_BR), 32'h7FFFFFEA, 32'd0, 1'b1);
        checkOutput("far_pc_const", PC, 32'hFFFFFFFC);
        applyInsn("wrap", makeInsn(OPC_I), 32'd0, 32'd0, 1'b0);
        checkOutput("wrap_pc_const", PC, 32'h0);
        checkOutput("wrap_busy", 32'(busy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
